// File: rtl/dark_fetch_ctrl.sv
// dark_fetch_ctrl
//   Instruction fetch controller. Issues one word fetch at a time to the
//   instruction memory. It holds the fetched word for decode until decode
//   accepts it, and it drives the program-counter load strobe.
//   A redirect overrides everything except IDLE. A fetch that is still in
//   flight when a redirect arrives is drained in FLUSH, and its data is
//   dropped.
//
// Optional feature: define DARK_IRQ_EN to enable the interrupt take / return
//   logic. Without it, irq and irq_ret are ignored and epc is tied to zero.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   IRQ_VEC   interrupt target address
//
// Ports
//   clk, res               clock; asynchronous active-high reset
//   imem_req/addr          fetch request and word address (out)
//   imem_ack/data          fetch completion and data, same cycle (in)
//   inst/inst_pc/valid     instruction presented to decode (out)
//   inst_ready             decode accepts inst (in)
//   redir/redir_pc         branch/jump redirect and its target (in)
//   pc_en/nxpc             PC register load strobe and value (out)
//   irq/irq_ret            level interrupt request, return pulse (in)
//   epc                    saved return address (out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | reset just released, no request outstanding
// FETCH | request at fpc outstanding
// VALID | fetched word held for decode, no request outstanding
// FLUSH | redirected while a request was in flight; drain it, drop data
module dark_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] IRQ_VEC  = 32'h00000010
) (
  input  logic        clk,
  input  logic        res,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redir,
  input  logic [31:0] redir_pc,
  output logic        pc_en,
  output logic [31:0] nxpc,
  input  logic        irq,
  input  logic        irq_ret,
  output logic [31:0] epc
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_fpc;
  logic [31:0] r_flush_addr;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_fpc_nxt;
  logic [31:0] w_fpc_inc;
  logic [31:0] w_redir_tgt;
  logic        w_pc_en;
  logic [31:0] w_nxpc;
  logic        w_load_inst;
  logic        w_save_flush;
  logic        w_take;
  logic        w_unused;

  assign w_fpc_inc   = r_fpc + 32'd4;
  assign w_redir_tgt = {redir_pc[31:2], 2'b00};

`ifdef DARK_IRQ_EN
  logic        r_irq_act;
  logic [31:0] r_epc;
  assign w_unused = ^redir_pc[1:0];
`else
  assign w_unused = ^{redir_pc[1:0], irq, irq_ret, IRQ_VEC};
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_fpc_nxt    = r_fpc;
    w_pc_en      = 1'b0;
    w_nxpc       = r_fpc;
    w_load_inst  = 1'b0;
    w_save_flush = 1'b0;
    w_take       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (redir) begin
          w_pc_en   = 1'b1;
          w_nxpc    = w_redir_tgt;
          w_fpc_nxt = w_redir_tgt;
          if (imem_ack) begin
            w_state_nxt = S_FETCH;
          end else begin
            // Memory still owes us the old word: remember its address so
            // the request stays stable while fpc moves to the target.
            w_state_nxt  = S_FLUSH;
            w_save_flush = 1'b1;
          end
        end else if (imem_ack) begin
          w_load_inst = 1'b1;
          w_pc_en     = 1'b1;
          w_nxpc      = w_fpc_inc;
          w_fpc_nxt   = w_fpc_inc;
          w_state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (redir) begin
          w_pc_en     = 1'b1;
          w_nxpc      = w_redir_tgt;
          w_fpc_nxt   = w_redir_tgt;
          w_state_nxt = S_FETCH;
        end else if (inst_ready) begin
          w_state_nxt = S_FETCH;
`ifdef DARK_IRQ_EN
          if (irq && !r_irq_act) begin
            w_take    = 1'b1;
            w_pc_en   = 1'b1;
            w_nxpc    = IRQ_VEC;
            w_fpc_nxt = IRQ_VEC;
          end
`endif
        end
      end
      S_FLUSH: begin
        if (redir) begin
          w_pc_en   = 1'b1;
          w_nxpc    = w_redir_tgt;
          w_fpc_nxt = w_redir_tgt;
        end
        if (imem_ack) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state      <= S_IDLE;
      r_fpc        <= RESET_PC;
      r_flush_addr <= RESET_PC;
      r_inst       <= 32'h0;
      r_inst_pc    <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_fpc   <= w_fpc_nxt;
      if (w_save_flush) begin
        r_flush_addr <= r_fpc;
      end
      if (w_load_inst) begin
        r_inst    <= imem_data;
        r_inst_pc <= r_fpc;
      end
    end
  end

`ifdef DARK_IRQ_EN
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_irq_act <= 1'b0;
      r_epc     <= 32'h0;
    end else begin
      // A take in the same cycle as irq_ret wins, leaving the flag set.
      if (w_take) begin
        r_irq_act <= 1'b1;
        r_epc     <= r_inst_pc + 32'd4;
      end else if (irq_ret) begin
        r_irq_act <= 1'b0;
      end
    end
  end
  assign epc = r_epc;
`else
  assign epc = 32'h0;
`endif

  assign imem_req   = (r_state == S_FETCH) || (r_state == S_FLUSH);
  assign imem_addr  = (r_state == S_FLUSH) ? r_flush_addr : r_fpc;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = (r_state == S_VALID);
  // The PC register is loaded with RESET_PC for as long as reset is held.
  assign pc_en      = res | w_pc_en;
  assign nxpc       = res ? RESET_PC : w_nxpc;

endmodule

// File: tb/tb_dark_fetch_ctrl.sv
module tb_dark_fetch_ctrl;

  logic        clk;
  logic        res;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redir;
  logic [31:0] redir_pc;
  logic        pc_en;
  logic [31:0] nxpc;
  logic        irq;
  logic        irq_ret;
  logic [31:0] epc;

  logic        force_ack;
  int          ack_dly;
  int          checks;
  int          errors;

  logic [31:0] q_fetch[$];
  logic [31:0] q_pc[$];
  logic [63:0] q_inst[$];

  dark_fetch_ctrl dut (
    .clk        (clk),
    .res        (res),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .redir      (redir),
    .redir_pc   (redir_pc),
    .pc_en      (pc_en),
    .nxpc       (nxpc),
    .irq        (irq),
    .irq_ret    (irq_ret),
    .epc        (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_imem_req"},   32'(imem_req),   32'h0);
    chk({tag, "_imem_addr"},  imem_addr,       32'h0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'h0);
    chk({tag, "_inst"},       inst,            32'h0);
    chk({tag, "_inst_pc"},    inst_pc,         32'h0);
    chk({tag, "_pc_en"},      32'(pc_en),      32'h1);
    chk({tag, "_nxpc"},       nxpc,            32'h0);
    chk({tag, "_epc"},        epc,             32'h0);
  endtask

  task automatic wait_valid(input logic [31:0] pc);
    int n;
    n = 0;
    while (!(inst_valid && inst_pc == pc) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!(inst_valid && inst_pc == pc)) begin
      errors++;
      $display("FAIL wait_valid timeout actual_pc=%h required_pc=%h", inst_pc, pc);
    end
  endtask

  task automatic wait_fetch(input logic [31:0] a, input logic want_ack);
    int n;
    n = 0;
    while (!(imem_req && imem_ack == want_ack && imem_addr == a) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!(imem_req && imem_ack == want_ack && imem_addr == a)) begin
      errors++;
      $display("FAIL wait_fetch timeout actual_addr=%h required_addr=%h", imem_addr, a);
    end
  endtask

  task automatic push_i(input logic [31:0] a);
    q_inst.push_back({a, mem_word(a)});
  endtask

  // Memory responder: acks ack_dly cycles into a request, or forces ack.
  initial begin
    int cnt;
    cnt = 0;
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (force_ack) begin
        imem_ack  = 1'b1;
        imem_data = 32'hBAD0BAD0;
      end else if (res || imem_ack) begin
        imem_ack = 1'b0;
        cnt = 0;
      end else if (imem_req) begin
        if (cnt >= ack_dly) begin
          imem_ack  = 1'b1;
          imem_data = mem_word(imem_addr);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (imem_req && imem_ack) begin
        if (q_fetch.size() == 0) begin
          checks++; errors++;
          $display("FAIL fetch_addr unexpected actual=%h required=none", imem_addr);
        end else begin
          chk("fetch_addr", imem_addr, q_fetch.pop_front());
        end
      end
      if (!res && pc_en) begin
        if (q_pc.size() == 0) begin
          checks++; errors++;
          $display("FAIL nxpc unexpected actual=%h required=none", nxpc);
        end else begin
          chk("nxpc", nxpc, q_pc.pop_front());
        end
      end
      if (inst_valid && inst_ready) begin
        if (q_inst.size() == 0) begin
          checks++; errors++;
          $display("FAIL inst unexpected actual_pc=%h required=none", inst_pc);
        end else begin
          e = q_inst.pop_front();
          chk("inst_pc", inst_pc, e[63:32]);
          chk("inst", inst, e[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    res = 1'b1; inst_ready = 1'b1; redir = 1'b0; redir_pc = 32'h0;
    irq = 1'b0; irq_ret = 1'b0; force_ack = 1'b0; ack_dly = 1;
    tick(); tick();
    force_ack = 1'b1;
    tick(); tick();
    check_reset("rst");

    // Sequential fetch 0,4,8 with one-cycle ack latency.
    q_fetch.push_back(32'h0); q_fetch.push_back(32'h4); q_fetch.push_back(32'h8);
    q_pc.push_back(32'h4); q_pc.push_back(32'h8); q_pc.push_back(32'hC);
    push_i(32'h0); push_i(32'h4);
    force_ack = 1'b0; res = 1'b0;
    tick();
    chk("rel_req", 32'(imem_req), 32'h1);
    chk("rel_addr", imem_addr, 32'h0);

    // Decode stall at 8 with stray acks in VALID.
    wait_valid(32'h8);
    inst_ready = 1'b0; force_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(inst_valid), 32'h1);
      chk("stall_inst", inst, mem_word(32'h8));
      chk("stall_pc", inst_pc, 32'h8);
      chk("stall_req", 32'(imem_req), 32'h0);
    end

    // Redirect to 0x103 while fetch at 12 is waiting on a slow ack.
    push_i(32'h8);
    q_fetch.push_back(32'hC); q_pc.push_back(32'h100);
    q_fetch.push_back(32'h100); q_pc.push_back(32'h104);
    ack_dly = 3; force_ack = 1'b0; inst_ready = 1'b1;
    wait_fetch(32'hC, 1'b0);
    redir = 1'b1; redir_pc = 32'h103;
    tick();
    redir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_req", 32'(imem_req), 32'h1);
      chk("flush_addr", imem_addr, 32'hC);
      if (i < 2) tick();
    end

    // Redirect in VALID to the top word, then fetch wraps to 0.
    wait_valid(32'h100);
    q_pc.push_back(32'hFFFFFFFC);
    q_fetch.push_back(32'hFFFFFFFC); q_pc.push_back(32'h0); push_i(32'hFFFFFFFC);
    q_fetch.push_back(32'h0); q_pc.push_back(32'h20);
    ack_dly = 1; inst_ready = 1'b0; redir = 1'b1; redir_pc = 32'hFFFFFFFF;
    tick();
    redir = 1'b0; inst_ready = 1'b1;
    chk("redir_valid_drop", 32'(inst_valid), 32'h0);

    // Redirect to 0x20 in the same cycle as the ack of fetch 0.
    wait_fetch(32'h0, 1'b1);
`ifdef DARK_IRQ_EN
    q_fetch.push_back(32'h20); q_pc.push_back(32'h24); push_i(32'h20);
    q_pc.push_back(32'h10);
    q_fetch.push_back(32'h10); q_pc.push_back(32'h14); push_i(32'h10);
    q_fetch.push_back(32'h14); q_pc.push_back(32'h18); push_i(32'h14);
    q_fetch.push_back(32'h18); q_pc.push_back(32'h1C); push_i(32'h18);
    q_pc.push_back(32'h10);
    q_fetch.push_back(32'h10); q_pc.push_back(32'h14);
`else
    q_fetch.push_back(32'h20); q_pc.push_back(32'h24); push_i(32'h20);
    q_fetch.push_back(32'h24); q_pc.push_back(32'h28); push_i(32'h24);
    q_fetch.push_back(32'h28); q_pc.push_back(32'h2C);
`endif
    redir = 1'b1; redir_pc = 32'h20; irq = 1'b1;
    tick();
    redir = 1'b0;
    chk("redir_ack_drop", 32'(inst_valid), 32'h0);

`ifdef DARK_IRQ_EN
    wait_valid(32'h14);
    irq_ret = 1'b1;
    tick();
    irq_ret = 1'b0;
    wait_valid(32'h18);
    chk("epc_first", epc, 32'h24);
    tick();
    wait_valid(32'h10);
    inst_ready = 1'b0; irq = 1'b0;
    chk("epc_second", epc, 32'h1C);
    push_i(32'h10);
`else
    wait_valid(32'h24);
    irq_ret = 1'b1;
    tick();
    irq_ret = 1'b0;
    wait_valid(32'h28);
    inst_ready = 1'b0; irq = 1'b0;
    chk("epc_off", epc, 32'h0);
    push_i(32'h28);
`endif

    // Asynchronous reset in the middle of a fetch.
    ack_dly = 3; inst_ready = 1'b1;
    tick();
    chk("pre_rst_req", 32'(imem_req), 32'h1);
    #1;
    res = 1'b1;
    #1;
    check_reset("rst_mid");
    force_ack = 1'b1;
    tick(); tick();
    chk("rst_ack_req", 32'(imem_req), 32'h0);
    q_fetch.push_back(32'h0); q_pc.push_back(32'h4);
    ack_dly = 1; force_ack = 1'b0; res = 1'b0;
    tick();
    chk("rel2_req", 32'(imem_req), 32'h1);
    chk("rel2_addr", imem_addr, 32'h0);
    wait_valid(32'h0);
    inst_ready = 1'b0;
    chk("rel2_inst", inst, mem_word(32'h0));
    tick(); tick(); tick();

    chk("q_fetch_left", q_fetch.size(), 32'h0);
    chk("q_pc_left", q_pc.size(), 32'h0);
    chk("q_inst_left", q_inst.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
